// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Holds the loader FSM encoding and the byte-to-word assembly helper.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_BYTES_LOG2 = 2;

  // Byte 0 starts a fresh word, so the upper lanes read as zero on a truncated word
  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  data);
    logic [31:0] w;
    w = (idx == 2'd0) ? 32'h0000_0000 : word;
    w[{idx, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [63:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     core_hold,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [1:0]    LAST_IDX   = 2'(BYTES_PER_WORD - 1);
  localparam logic [63:0]   ADDR_STEP  = 64'(1) << WORD_BYTES_LOG2;

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    r_idx;
  logic [1:0]    w_next_idx;
  logic          r_last;
  logic          w_next_last;
  logic          w_set_err;
  logic          w_ready;
  logic          w_accept;
  logic          w_full;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_hold;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_count;

  assign w_ready  = (r_state == IDLE) || (r_state == COLLECT);
  assign w_accept = in_valid && w_ready;
  assign w_full   = (r_count == FULL_COUNT);

  // Next-state, byte index and error-event decode
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_last  = r_last;
    w_set_err    = 1'b0;
    case (r_state)
      IDLE, COLLECT: begin
        if (!w_accept) begin
          w_next_state = r_state;
        end else if (w_full) begin
          // Memory is full: drop the byte but let the source drain to in_last
          w_set_err    = 1'b1;
          w_next_state = in_last ? DONE : COLLECT;
        end else if (in_last || (r_idx == LAST_IDX)) begin
          w_next_state = WRITE;
          w_next_last  = in_last;
          w_set_err    = in_last && (r_idx != LAST_IDX);
        end else begin
          w_next_state = COLLECT;
          w_next_idx   = r_idx + 2'd1;
        end
      end
      WRITE: begin
        w_next_idx   = 2'd0;
        w_next_state = r_last ? DONE : COLLECT;
      end
      DONE: begin
        w_next_state = DONE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, assembler and registered output updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_last  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= 32'h0000_0000;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_last  <= w_next_last;
      r_we    <= (w_next_state == WRITE);
      r_hold  <= (w_next_state != DONE);
      r_done  <= (w_next_state == DONE);
      r_err   <= r_err | w_set_err;
      if (w_accept && !w_full) begin
        r_wdata <= insert_byte(r_wdata, r_idx, in_data);
      end else begin
        r_wdata <= r_wdata;
      end
      if ((r_state == WRITE) && !w_full) begin
        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        r_addr  <= r_addr + ADDR_STEP;
      end else begin
        r_count <= r_count;
        r_addr  <= r_addr;
      end
    end
  end

  assign in_ready   = w_ready;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_hold  = r_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for the streaming case plus
// hand sequences for truncation, overflow (DEPTH=4) and reset mid-load.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;

  logic        ready1, we1, hold1, done1, err1;
  logic [63:0] addr1;
  logic [31:0] wdata1;
  logic [8:0]  cnt1;

  logic        ready2, we2, hold2, done2, err2;
  logic [63:0] addr2;
  logic [31:0] wdata2;
  logic [2:0]  cnt2;

  int n_checks;
  int n_errors;

  logic [63:0] wq1_addr[$];
  logic [31:0] wq1_data[$];
  logic [63:0] wq2_addr[$];
  logic [31:0] wq2_data[$];

  imem_loader #(.DEPTH(256), .BASE_ADDR(64'h0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ready1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .core_hold(hold1), .done(done1), .err(err1), .word_count(cnt1)
  );

  imem_loader #(.DEPTH(4), .BASE_ADDR(64'h0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(ready2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
    .core_hold(hold2), .done(done2), .err(err2), .word_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we1) begin
      wq1_addr.push_back(addr1);
      wq1_data.push_back(wdata1);
    end
    if (we2) begin
      wq2_addr.push_back(addr2);
      wq2_data.push_back(wdata2);
    end
  end

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        e_we;
    logic [63:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_hold;
    logic        e_done;
    logic        e_err;
    logic [8:0]  e_cnt;
    logic        e_ready;
  } vec_t;

  vec_t vecs [0:10];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                              input logic e_we, input logic [63:0] e_addr,
                              input logic [31:0] e_wdata, input logic e_hold,
                              input logic e_done, input logic e_err,
                              input logic [8:0] e_cnt, input logic e_ready);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata;
    r.e_hold = e_hold; r.e_done = e_done; r.e_err = e_err; r.e_cnt = e_cnt; r.e_ready = e_ready;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_ready"}, 64'(ready1), 64'd1);
    check({tag, "_we"},    64'(we1),    64'd0);
    check({tag, "_addr"},  addr1,       64'h0);
    check({tag, "_wdata"}, 64'(wdata1), 64'h0);
    check({tag, "_hold"},  64'(hold1),  64'd1);
    check({tag, "_done"},  64'(done1),  64'd0);
    check({tag, "_err"},   64'(err1),   64'd0);
    check({tag, "_cnt"},   64'(cnt1),   64'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    wq1_addr.delete(); wq1_data.delete();
    wq2_addr.delete(); wq2_data.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l, input bit sel2);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!(sel2 ? ready2 : ready1) && (n < 10)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 10) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout actual=%0d expected=<10", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit sel2);
    int n;
    n = 0;
    while (!(sel2 ? done2 : done1) && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout actual=%0d expected=<20", n);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    // Two full words with in_valid held high across the WRITE cycles
    vecs[0]  = mk(1'b1, 8'h13, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0, 1'b1);
    vecs[1]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0, 1'b1);
    vecs[2]  = mk(1'b1, 8'h50, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0, 1'b1);
    vecs[3]  = mk(1'b1, 8'h00, 1'b0, 1'b1, 64'h0, 32'h00500013, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0);
    vecs[4]  = mk(1'b1, 8'h93, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1, 1'b1);
    vecs[5]  = mk(1'b1, 8'h93, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1, 1'b1);
    vecs[6]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1, 1'b1);
    vecs[7]  = mk(1'b1, 8'h10, 1'b0, 1'b0, 64'h0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd1, 1'b1);
    vecs[8]  = mk(1'b1, 8'h00, 1'b1, 1'b1, 64'h4, 32'h00100093, 1'b1, 1'b0, 1'b0, 9'd1, 1'b0);
    vecs[9]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 64'h0, 32'h0,        1'b0, 1'b1, 1'b0, 9'd2, 1'b0);
    vecs[10] = mk(1'b1, 8'hFF, 1'b1, 1'b0, 64'h0, 32'h0,        1'b0, 1'b1, 1'b0, 9'd2, 1'b0);

    do_reset();
    check_reset1("rst0");

    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      in_last  = vecs[i].l;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_we", i),    64'(we1),    64'(vecs[i].e_we));
      check($sformatf("v%0d_hold", i),  64'(hold1),  64'(vecs[i].e_hold));
      check($sformatf("v%0d_done", i),  64'(done1),  64'(vecs[i].e_done));
      check($sformatf("v%0d_err", i),   64'(err1),   64'(vecs[i].e_err));
      check($sformatf("v%0d_cnt", i),   64'(cnt1),   64'(vecs[i].e_cnt));
      check($sformatf("v%0d_ready", i), 64'(ready1), 64'(vecs[i].e_ready));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addr", i),  addr1,       vecs[i].e_addr);
        check($sformatf("v%0d_wdata", i), 64'(wdata1), 64'(vecs[i].e_wdata));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("two_words_nwrites", 64'(wq1_addr.size()), 64'd2);

    // Truncated final word: upper byte zero-filled, err raised
    do_reset();
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b1, 1'b0);
    wait_done(1'b0);
    check("trunc_nwrites", 64'(wq1_addr.size()), 64'd1);
    if (wq1_addr.size() == 1) begin
      check("trunc_addr",  wq1_addr[0],      64'h0);
      check("trunc_wdata", 64'(wq1_data[0]), 64'h00CCBBAA);
    end
    check("trunc_err",  64'(err1),  64'd1);
    check("trunc_done", 64'(done1), 64'd1);
    check("trunc_hold", 64'(hold1), 64'd0);
    check("trunc_cnt",  64'(cnt1),  64'd1);

    // Overflow on the DEPTH=4 instance: 20 bytes, last four dropped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i >= 17) begin
        check($sformatf("ovf_ready_b%0d", i), 64'(ready2), 64'd1);
      end
      send(8'(i), (i == 19), 1'b1);
    end
    check("ovf_done_now", 64'(done2), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_nwrites", 64'(wq2_addr.size()), 64'd4);
    for (int w = 0; w < 4; w++) begin
      if (w < wq2_addr.size()) begin
        check($sformatf("ovf_addr%0d", w), wq2_addr[w], 64'(4 * w));
        check($sformatf("ovf_data%0d", w), 64'(wq2_data[w]),
              64'({8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)}));
      end
    end
    check("ovf_cnt",  64'(cnt2),  64'd4);
    check("ovf_err",  64'(err2),  64'd1);
    check("ovf_done", 64'(done2), 64'd1);
    check("ovf_hold", 64'(hold2), 64'd0);

    // Reset mid-load after 6 bytes, then a fresh single-word program
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(8'h60 + 8'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset1("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    wq1_addr.delete();
    wq1_data.delete();
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    wait_done(1'b0);
    check("mid_nwrites", 64'(wq1_addr.size()), 64'd1);
    if (wq1_addr.size() == 1) begin
      check("mid_addr",  wq1_addr[0],      64'h0);
      check("mid_wdata", 64'(wq1_data[0]), 64'h44332211);
    end
    check("mid_cnt",  64'(cnt1),  64'd1);
    check("mid_err",  64'(err1),  64'd0);
    check("mid_done", 64'(done1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory read by the pipeline's IF stage. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each completed word is written to consecutive word addresses starting at `BASE_ADDR`. The core is held in reset until the final byte has been committed, so the IF stage never fetches a partially loaded program.

## Interface
- `DEPTH`, 256: instruction memory capacity in 32-bit words; must be a power of two.
- `BASE_ADDR`, 64'h0: byte address of the first word written.
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  `in_data` and `in_last` are valid.
- `in_data`  input  8  program byte.
- `in_last`  input  1  marks the final byte of the program.
- `in_ready`  output  1  loader can accept a byte this cycle.
- `mem_we`  output  1  instruction memory write strobe.
- `mem_addr`  output  64  byte address of the word being written.
- `mem_wdata`  output  32  instruction word.
- `core_hold`  output  1  holds the datapath in reset while high.
- `done`  output  1  load complete (sticky).
- `err`  output  1  truncated final word or overflow (sticky).
- `word_count`  output  $clog2(DEPTH)+1  number of words written.

## Operation
- A byte transfers on any cycle where `in_valid && in_ready` at the rising edge.
- **States:**
  - IDLE: `in_ready`=1. The first accepted byte goes to COLLECT with byte index 1.
  - COLLECT: `in_ready`=1. Bytes are accepted in order; byte k (0..3) lands in `mem_wdata[8k+7:8k]`.
    - The 4th byte, or `in_last` on any byte, moves to WRITE.
  - WRITE: lasts one cycle.
    - `mem_we`=1 and `in_ready`=0.
    - `mem_addr` = `BASE_ADDR` + 4·`word_count`.
    - `word_count` increments at the end of the cycle.
    - The byte index clears.
    - Next state is DONE if the word was closed by `in_last`, otherwise COLLECT.
  - DONE: `in_ready`=0, `core_hold`=0, `done`=1. The loader stays here until reset.
- **Truncated final word:** if `in_last` arrives on byte index 0–2, the unfilled upper bytes are written as zero and `err` is set.
- **Overflow:** once `word_count` == `DEPTH`, accepted bytes are dropped and `err` is set.
  - No WRITE cycle occurs.
  - `in_ready` stays 1 so the source can drain.
  - `in_last` then moves to DONE.
- `core_hold` = 1 in every state except DONE.
- `word_count` saturates at `DEPTH` and never wraps.

## Timing
- **Reset values:** state IDLE, `in_ready`=1, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `core_hold`=1, `done`=0, `err`=0, `word_count`=0.
- **Registered outputs:** `mem_we`, `mem_addr`, `mem_wdata`, `core_hold`, `done`, `err` and `word_count` are registered.
- **Combinational output:** `in_ready` is decoded combinationally from state.
- **Write latency:** the 4th byte is accepted at edge N, and `mem_we` is high for exactly the cycle between edges N and N+1.
- **Throughput:** maximum is 4 bytes per 5 cycles.
- **Hold time:** `mem_addr` and `mem_wdata` remain stable through the WRITE cycle.
- **Core release:** `core_hold` falls on the edge that ends the final WRITE cycle. At that same edge `done` rises.
- **Back-pressure:** in WRITE, a source holding `in_valid` must keep `in_data` stable. The byte is accepted on the first cycle back in COLLECT.
- **Reset mid-load:** asserting `rst` at any point returns all outputs to reset values immediately. Any partial word is discarded, and `core_hold` is reasserted.
- `in_last` with `in_valid` low is ignored.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum (`IDLE`, `COLLECT`, `WRITE`, `DONE`);
  - `BYTES_PER_WORD` = 4;
  - `WORD_BYTES_LOG2` = 2.
- The block is a single flat module with no sub-module; the byte assembler is a 32-bit shift/insert register inside it.

## Test plan
- **Two full words:** stream 13 00 50 00, 93 00 10 00 with `in_last` on the 8th byte.
  - Writes 32'h00500013 at addr 0 and 32'h00100093 at addr 4.
  - `word_count`=2, `done`=1, `err`=0, `core_hold` falls after the 2nd write.
- **Truncated last word:** stream AA BB CC with `in_last` on CC.
  - One write of 32'h00CCBBAA at addr 0, `err`=1, `done`=1.
- **Back-pressure:** hold `in_valid`=1 continuously across 8 bytes.
  - `in_ready` drops for exactly one cycle after bytes 4 and 8.
  - No byte is lost or duplicated; words match the byte order.
- **Overflow:** with `DEPTH`=4, stream 20 bytes, `in_last` on byte 20.
  - Four writes at addrs 0, 4, 8, C; no 5th `mem_we`.
  - `word_count`=4, `err`=1, `done`=1.
- **Reset mid-load:** assert `rst` after 6 bytes, then stream 4 fresh bytes with `in_last`.
  - All outputs return to reset values while `rst` is low.
  - After release, the single write lands at addr 0 with the fresh data and `word_count`=1.
